// File: rtl/trap_sequencer_pkg.sv
// Shared types and constants for the machine-mode trap/return sequencer.
// Holds the CSR index enum, sequencer states and MSTATUS field helpers.
package trap_sequencer_pkg;

    typedef enum logic [11:0] {
        MSTATUS  = 12'h300,
        MTVEC    = 12'h305,
        MSCRATCH = 12'h340,
        MEPC     = 12'h341,
        MCAUSE   = 12'h342,
        MTVAL    = 12'h343
    } destinationCSR_;

    typedef enum logic [2:0] {
        IDLE,
        T_EPC,
        T_CAUSE,
        T_TVAL,
        T_STAT,
        T_VEC,
        R_STAT,
        R_EPC
    } trapState_;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam logic [31:0] CAUSE_ILLEGAL_INSN = 32'h0000_0002;
    localparam logic [31:0] CAUSE_BREAKPOINT   = 32'h0000_0003;
    localparam logic [31:0] CAUSE_LOAD_MISALGN = 32'h0000_0004;
    localparam logic [31:0] CAUSE_ECALL_M      = 32'h0000_000B;
    localparam logic [31:0] CAUSE_M_EXT_IRQ    = 32'h8000_000B;

    // Trap entry: stack MIE into MPIE, mask interrupts, previous privilege = M.
    function automatic logic [31:0] mstatusOnTrap(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MPIE] = s[MSTATUS_MIE];
        r[MSTATUS_MIE]  = 1'b0;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mstatusOnMret(input logic [31:0] s);
        logic [31:0] r;
        r = s;
        r[MSTATUS_MIE]  = s[MSTATUS_MPIE];
        r[MSTATUS_MPIE] = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

endpackage

// File: rtl/trap_sequencer_if.sv
// Pipeline/CSR-file bundle seen by the trap sequencer.
// master = pipeline + CSR file side, slave = sequencer.
interface trap_sequencer_if import trap_sequencer_pkg::*; ();

    logic           trapRequest;
    logic [31:0]    trapCause;
    logic [31:0]    trapPc;
    logic [31:0]    trapValue;
    logic           mretRequest;
    logic           interrupt;
    logic [31:0]    commitPc;
    logic           pipeCsrWrite;
    destinationCSR_ pipeCsrDest;
    logic [31:0]    pipeCsrData;
    destinationCSR_ pipeCsrRead;
    logic [31:0]    csrReadData;
    destinationCSR_ readCSR;
    destinationCSR_ destinationCSR;
    logic [31:0]    csrWriteData;
    logic           csrDestinationEnable;
    logic           flush;
    logic           busy;
    logic           redirectValid;
    logic [31:0]    redirectPc;

    modport master (
        output trapRequest, trapCause, trapPc, trapValue, mretRequest, interrupt,
               commitPc, pipeCsrWrite, pipeCsrDest, pipeCsrData, pipeCsrRead,
               csrReadData,
        input  readCSR, destinationCSR, csrWriteData, csrDestinationEnable,
               flush, busy, redirectValid, redirectPc
    );

    modport slave (
        input  trapRequest, trapCause, trapPc, trapValue, mretRequest, interrupt,
               commitPc, pipeCsrWrite, pipeCsrDest, pipeCsrData, pipeCsrRead,
               csrReadData,
        output readCSR, destinationCSR, csrWriteData, csrDestinationEnable,
               flush, busy, redirectValid, redirectPc
    );

endinterface

// File: rtl/trap_sequencer.sv
// Machine-mode trap entry / MRET sequencer owning the CSR file ports.
// Define TRAP_VECTORED_EN to honour MTVEC vectored mode for interrupts.
module trap_sequencer import trap_sequencer_pkg::*; #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] IRQ_CAUSE = CAUSE_M_EXT_IRQ
) (
    input  logic             clock,
    input  logic             reset,
    trap_sequencer_if.slave  bus
);

    trapState_   r_state;
    trapState_   w_next;
    logic [31:0] r_cause;
    logic [31:0] r_pc;
    logic [31:0] r_value;

    logic        w_idle;
    logic        w_mie;
    logic        w_accTrap;
    logic        w_accMret;
    logic        w_accIrq;
    logic [31:0] w_base;
    logic [31:0] w_baseEff;
    logic [31:0] w_vecPc;

    assign w_idle    = (r_state == IDLE);
    // MSTATUS is only on the read port when the pipeline is not writing.
    assign w_mie     = !bus.pipeCsrWrite && bus.csrReadData[MSTATUS_MIE];
    assign w_accTrap = w_idle && bus.trapRequest;
    assign w_accMret = w_idle && !bus.trapRequest && bus.mretRequest;
    assign w_accIrq  = w_idle && !bus.trapRequest && !bus.mretRequest
                       && bus.interrupt && w_mie;

    assign w_base    = {bus.csrReadData[31:2], 2'b00};
    assign w_baseEff = (w_base == '0) ? RESET_PC : w_base;

`ifdef TRAP_VECTORED_EN
    assign w_vecPc = (bus.csrReadData[1:0] == 2'b01 && r_cause[31])
                     ? w_baseEff + {r_cause[29:0], 2'b00} : w_baseEff;
`else
    assign w_vecPc = w_baseEff;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_cause <= '0;
            r_pc    <= '0;
            r_value <= '0;
        end else begin
            r_state <= w_next;
            if (w_accTrap) begin
                r_cause <= bus.trapCause;
                r_pc    <= bus.trapPc;
                r_value <= bus.trapValue;
            end else if (w_accIrq) begin
                r_cause <= IRQ_CAUSE;
                r_pc    <= bus.commitPc;
                r_value <= '0;
            end
        end
    end

    always_comb begin
        w_next                   = r_state;
        bus.readCSR              = bus.pipeCsrRead;
        bus.destinationCSR       = destinationCSR_'(12'h000);
        bus.csrWriteData         = '0;
        bus.csrDestinationEnable = 1'b0;
        bus.flush                = 1'b0;
        bus.busy                 = 1'b0;
        bus.redirectValid        = 1'b0;
        bus.redirectPc           = '0;
        // Outputs are held quiet while reset is asserted, independent of state.
        if (reset) begin
            bus.busy = (r_state != IDLE);
            case (r_state)
                IDLE: begin
                    if (!bus.pipeCsrWrite) bus.readCSR = MSTATUS;
                    if (w_accTrap || w_accIrq) begin
                        bus.flush = 1'b1;
                        w_next    = T_EPC;
                    end else if (w_accMret) begin
                        bus.flush = 1'b1;
                        w_next    = R_STAT;
                    end else begin
                        bus.destinationCSR       = bus.pipeCsrDest;
                        bus.csrWriteData         = bus.pipeCsrData;
                        bus.csrDestinationEnable = bus.pipeCsrWrite;
                    end
                end
                T_EPC: begin
                    bus.destinationCSR       = MEPC;
                    bus.csrWriteData         = r_pc & ~32'h3;
                    bus.csrDestinationEnable = 1'b1;
                    w_next                   = T_CAUSE;
                end
                T_CAUSE: begin
                    bus.destinationCSR       = MCAUSE;
                    bus.csrWriteData         = r_cause;
                    bus.csrDestinationEnable = 1'b1;
                    w_next                   = T_TVAL;
                end
                T_TVAL: begin
                    bus.destinationCSR       = MTVAL;
                    bus.csrWriteData         = r_value;
                    bus.csrDestinationEnable = 1'b1;
                    w_next                   = T_STAT;
                end
                T_STAT: begin
                    bus.readCSR              = MSTATUS;
                    bus.destinationCSR       = MSTATUS;
                    bus.csrWriteData         = mstatusOnTrap(bus.csrReadData);
                    bus.csrDestinationEnable = 1'b1;
                    w_next                   = T_VEC;
                end
                T_VEC: begin
                    bus.readCSR       = MTVEC;
                    bus.redirectValid = 1'b1;
                    bus.redirectPc    = w_vecPc;
                    w_next            = IDLE;
                end
                R_STAT: begin
                    bus.readCSR              = MSTATUS;
                    bus.destinationCSR       = MSTATUS;
                    bus.csrWriteData         = mstatusOnMret(bus.csrReadData);
                    bus.csrDestinationEnable = 1'b1;
                    w_next                   = R_EPC;
                end
                R_EPC: begin
                    bus.readCSR       = MEPC;
                    bus.redirectValid = 1'b1;
                    bus.redirectPc    = bus.csrReadData;
                    w_next            = IDLE;
                end
                default: w_next = IDLE;
            endcase
        end
    end

endmodule
